// File: rtl/shift_right_unit_pkg.sv
// Shared types, widths and word-extension helpers for the iterative right shifter.
package shift_pkg;

  localparam int XLEN   = 64;
  localparam int NSTAGE = 6;
  localparam int WLEN   = 32;

  localparam logic [2:0] LAST_STAGE = 3'(NSTAGE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
    return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
  endfunction

endpackage

// File: rtl/mux2_64.sv
// Plain 64-bit two-input multiplexer: selects i_b when i_sel is high.
module mux2_64 (
  input  logic        i_sel,
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  output logic [63:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/shift_right_unit_stage.sv
// One binary right-shift stage: shifts by 32>>i_idx with i_fill at the top when enabled.
module sr_stage_64
  import shift_pkg::*;
(
  input  logic [XLEN-1:0] i_opnd,
  input  logic            i_en,
  input  logic [2:0]      i_idx,
  input  logic            i_fill,
  output logic [XLEN-1:0] o_opnd
);

  logic [XLEN-1:0] w_shifted;

  // Candidate shifted operand for the stage selected by i_idx
  always_comb begin
    w_shifted = i_opnd;
    case (i_idx)
      3'd0:    w_shifted = {{32{i_fill}}, i_opnd[63:32]};
      3'd1:    w_shifted = {{16{i_fill}}, i_opnd[63:16]};
      3'd2:    w_shifted = {{8{i_fill}},  i_opnd[63:8]};
      3'd3:    w_shifted = {{4{i_fill}},  i_opnd[63:4]};
      3'd4:    w_shifted = {{2{i_fill}},  i_opnd[63:2]};
      3'd5:    w_shifted = {i_fill,       i_opnd[63:1]};
      default: w_shifted = i_opnd;
    endcase
  end

  mux2_64 u_mux (
    .i_sel (i_en),
    .i_a   (i_opnd),
    .i_b   (w_shifted),
    .o_y   (o_opnd)
  );

endmodule

// File: rtl/shift_right_unit.sv
// Iterative RV64 right shifter (SRL/SRA/SRLW/SRAW), one binary stage per clock,
// valid/ready on both sides with a fixed 7-cycle request-to-result latency.
module shift_right_unit
  import shift_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] din,
  input  logic [5:0]      shamt,
  input  logic            arith,
  input  logic            word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] dout,
  output logic            busy
);

  state_t          r_state;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_dout;
  logic [5:0]      r_shamt;
  logic            r_fill;
  logic            r_word;
  logic [2:0]      r_cnt;

  logic [XLEN-1:0] w_opnd_in;
  logic [5:0]      w_shamt_in;
  logic [XLEN-1:0] w_stage_out;

  // Working operand and effective shift amount as captured on accept
  always_comb begin
    w_opnd_in  = din;
    w_shamt_in = shamt;
    if (word) begin
      w_shamt_in = {1'b0, shamt[4:0]};
      if (arith) begin
        w_opnd_in = sext_word(din);
      end else begin
        w_opnd_in = zext_word(din);
      end
    end else begin
      w_opnd_in  = din;
      w_shamt_in = shamt;
    end
  end

  // r_shamt is shifted left each stage, so its MSB always holds the bit for the current stage
  sr_stage_64 u_stage (
    .i_opnd (r_opnd),
    .i_en   (r_shamt[5]),
    .i_idx  (r_cnt),
    .i_fill (r_fill),
    .o_opnd (w_stage_out)
  );

  // Control FSM plus operand, shift-amount, counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opnd  <= {XLEN{1'b0}};
      r_dout  <= {XLEN{1'b0}};
      r_shamt <= 6'd0;
      r_fill  <= 1'b0;
      r_word  <= 1'b0;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opnd  <= w_opnd_in;
            r_shamt <= w_shamt_in;
            r_fill  <= arith & w_opnd_in[XLEN-1];
            r_word  <= word;
            r_cnt   <= 3'd0;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_opnd  <= w_stage_out;
          r_shamt <= {r_shamt[4:0], 1'b0};
          if (r_cnt == LAST_STAGE) begin
            r_dout  <= r_word ? sext_word(w_stage_out) : w_stage_out;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign dout      = r_dout;

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed and randomized scoreboard bench for shift_right_unit.
module tb_shift_right_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] din;
  logic [5:0]  shamt;
  logic        arith;
  logic        word;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  shift_right_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shamt     (shamt),
    .arith     (arith),
    .word      (word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [5:0] s,
                                            input logic a, input logic w);
    logic [31:0] r32;
    logic [63:0] r64;
    if (w) begin
      if (a) r32 = 32'($signed(d[31:0]) >>> s[4:0]);
      else   r32 = d[31:0] >> s[4:0];
      return {{32{r32[31]}}, r32};
    end else begin
      if (a) r64 = 64'($signed(d) >>> s);
      else   r64 = d >> s;
      return r64;
    end
  endfunction

  // Drive one request at a negedge; accepted on the following posedge (cycle 0)
  task automatic send(input logic [63:0] d, input logic [5:0] s, input logic a,
                      input logic w, input logic [63:0] expv, input bit push);
    @(negedge clk);
    check("in_ready_before_send", {63'd0, in_ready}, 64'd1);
    din = d; shamt = s; arith = a; word = w; in_valid = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), check latency and scoreboard value
  task automatic collect(input string tag);
    int lat;
    logic [63:0] e;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd7);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, dout, e);
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_ack", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic op(input string tag, input logic [63:0] d, input logic [5:0] s,
                    input logic a, input logic w, input logic [63:0] expv);
    send(d, s, a, w, expv, 1'b1);
    collect(tag);
    ack();
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] rd;
    logic [5:0]  rs;
    logic        ra, rw;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din = 64'd0; shamt = 6'd0; arith = 1'b0; word = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_dout",      dout,               64'd0);

    op("srl_1",      64'h8000_0000_0000_0001, 6'd1,    1'b0, 1'b0, 64'h4000_0000_0000_0000);
    op("sra_63",     64'h8000_0000_0000_0000, 6'd63,   1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    op("sra_0",      64'h8000_0000_0000_0000, 6'd0,    1'b1, 1'b0, 64'h8000_0000_0000_0000);
    op("srlw_0",     64'hFFFF_FFFF_8000_0000, 6'd0,    1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000);
    op("srlw_24",    64'hFFFF_FFFF_8000_0000, 6'h24,   1'b0, 1'b1, 64'h0000_0000_0800_0000);
    op("sraw_31",    64'h0000_0000_8000_0000, 6'd31,   1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    op("sraw_4",     64'h0000_0000_7FFF_FFFF, 6'd4,    1'b1, 1'b1, 64'h0000_0000_07FF_FFFF);
    op("srl_ff_37",  64'hFFFF_FFFF_FFFF_FFFF, 6'd37,   1'b0, 1'b0, 64'h0000_0000_07FF_FFFF);

    for (int i = 0; i < 6; i++) begin
      rd = {$urandom(), $urandom()};
      rs = 6'($urandom_range(0, 63));
      ra = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      op("rand", rd, rs, ra, rw, ref_shift(rd, rs, ra, rw));
    end

    // Backpressure: result must hold while new requests are offered and ignored
    send(64'h0000_0000_0000_F000, 6'd8, 1'b0, 1'b0, 64'h0000_0000_0000_00F0, 1'b1);
    collect("bp_result");
    held = dout;
    for (int i = 0; i < 5; i++) begin
      din = {$urandom(), $urandom()}; shamt = 6'd3; in_valid = 1'b1;
      @(negedge clk);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_dout_held", dout, held);
      check("bp_in_ready",  {63'd0, in_ready},  64'd0);
    end
    in_valid = 1'b0;
    ack();
    repeat (2) @(negedge clk);
    check("bp_no_accept_busy", {63'd0, busy}, 64'd0);

    // Reset in the third SHIFT cycle discards the operation
    send(64'h1234_5678_9ABC_DEF0, 6'd12, 1'b0, 1'b0, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_dout",      dout,               64'd0);
    op("srl_after_rst", 64'h0000_0000_0000_00F0, 6'd4, 1'b0, 1'b0, 64'h0000_0000_0000_000F);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_right_unit.md
# shift_right_unit

Iterative 64-bit right shifter for the RV64 execute stage. It implements SRL, SRA, SRLW and SRAW as a valid/ready slave that resolves one binary shift stage per clock (32, 16, 8, 4, 2, 1). It is the right-shift counterpart of the single-cycle left shifter. It trades latency for a single 64-bit mux level per cycle, so the ALU timing path stays short.

## Interface
- XLEN, 64: datapath width. Only 64 is supported.
- NSTAGE, 6: number of shift stages, equal to log2(XLEN).

- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request; high only in IDLE
- din  input  64  operand
- shamt  input  6  shift amount; bit 5 ignored when word=1
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- word  input  1  1 = W-variant (32-bit op, sign-extended result)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- dout  output  64  result, held stable while out_valid=1
- busy  output  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch the working operand:
    - word=0: din.
    - word=1, arith=1: sign-extend din[31:0].
    - word=1, arith=0: zero-extend din[31:0].
  - Latch the effective shift amount: word ? {1'b0, shamt[4:0]} : shamt.
  - Latch fill = arith & operand[63].
  - Clear the stage counter and go to SHIFT.
- SHIFT:
  - Each cycle applies stage k (k = 0..5): if the effective shamt bit (5−k) is set, shift the operand right by 32>>k and insert fill bits at the top.
  - After k=5, go to DONE.
  - The stage counter is 3 bits and never passes 5.
- DONE:
  - out_valid=1.
  - dout = word ? sign-extend(result[31:0]) : result. The sign extension applies to SRLW too, e.g. shamt 0 on 0x8000_0000 gives 0xFFFF_FFFF_8000_0000.
  - On out_ready, go to IDLE.
- Every stage is always taken (a stage may be a no-op), so latency is fixed and independent of shamt.
- in_valid is ignored outside IDLE. Requests are not queued and there is no overlap.
- Synchronous reset (rst_n=0 at a rising edge), from any state including mid-SHIFT or DONE:
  - Go to IDLE, clear the operand, counter and dout.
  - Any pending result is discarded without handshake.
- Reset values: in_ready=1, out_valid=0, busy=0, dout=64'h0.

## Timing
- Accept cycle = cycle 0 (in_valid & in_ready sampled high at the end of cycle 0).
- Cycles 1–6: SHIFT, one stage per rising edge.
- Cycle 7: out_valid=1 and dout valid.
  - Result handshake in cycle 7 → in_ready=1 in cycle 8.
  - Minimum initiation interval is 8 cycles.
- With out_ready low, DONE holds indefinitely. dout and out_valid must not change.
- in_ready, out_valid and busy are pure decodes of the registered state. There is no combinational path from in_valid or out_ready to any output.
- dout is registered: updated on the edge into DONE, held until the next accept or reset.

## Structure
- Package shift_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - XLEN, NSTAGE, and a localparam for the word width, 32.
- Sub-module sr_stage_64, combinational:
  - Inputs: operand, enable, stage index, fill.
  - Output: operand shifted right by 32>>index with fill when enabled, else passthrough.
  - Built on the existing mux2_64.
- One instance, driven by the stage counter.
- The top level holds the FSM, the operand and shamt registers, and the word/sign-extension logic.

## Test plan
- SRL: din=0x8000_0000_0000_0001, shamt=1, arith=0, word=0 → dout=0x4000_0000_0000_0000, out_valid first high exactly in cycle 7.
- SRA:
  - din=0x8000_0000_0000_0000, shamt=63 → 0xFFFF_FFFF_FFFF_FFFF.
  - Same din, shamt=0 → 0x8000_0000_0000_0000.
- SRLW:
  - din=0xFFFF_FFFF_8000_0000, shamt=0 → 0xFFFF_FFFF_8000_0000.
  - shamt=0x24 (bit 5 ignored, effective 4) → 0x0000_0000_0800_0000.
- SRAW: din=0x0000_0000_8000_0000, shamt=31 → 0xFFFF_FFFF_FFFF_FFFF. Then din=0x7FFF_FFFF, shamt=4 → 0x0000_0000_07FF_FFFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands. dout and out_valid stay stable, in_ready=0, and the new request is not accepted. out_ready=1 → in_ready=1 the next cycle.
- Reset mid-operation: rst_n=0 in cycle 3 of SHIFT → next cycle state IDLE, in_ready=1, out_valid=0, dout=0. A subsequent SRL of 0xF0 by 4 returns 0x0F after 7 cycles.
